// File: rtl/wfg_drive_pwm.sv
// wfg_drive_pwm: PWM driver; duty reloaded from AXI-Stream on each sync, period counted in subcycle pulses.
// Optional saturating underrun counter on underrun_cnt_o when WFG_DRIVE_PWM_UNDERRUN_CNT_EN is defined.
module wfg_drive_pwm #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              en_i,
    input  logic [CNT_W-1:0]  period_i,
    input  logic              polarity_i,
    input  logic              wfg_pat_sync_i,
    input  logic              wfg_pat_subcycle_i,
    input  logic              wfg_pat_start_i,
    input  logic [DATA_W-1:0] wfg_axis_tdata_i,
    input  logic              wfg_axis_tvalid_i,
    output logic              wfg_axis_tready_o,
    output logic              pwm_o,
    output logic              active_o,
`ifdef WFG_DRIVE_PWM_UNDERRUN_CNT_EN
    output logic [15:0]       underrun_cnt_o,
`endif
    output logic              underrun_o
);
    typedef enum logic [1:0] {IDLE, WAIT_START, RUN} state_t;
    state_t           state, state_n;
    logic [CNT_W-1:0] phase_q, phase_n, duty_q, duty_n;
    logic [CNT_W:0]   p;
    logic             pwm_q, underrun_q, acc_ev, wrap;
    logic             unused_tdata;
    assign unused_tdata = ^wfg_axis_tdata_i;
    always_comb begin
        acc_ev  = en_i & wfg_pat_sync_i & (state == RUN | (state == WAIT_START & wfg_pat_start_i));
        p       = {period_i == '0, period_i};
        wrap    = {1'b0, phase_q} >= p - 1'b1;
        state_n = !en_i ? IDLE :
                  state == IDLE ? WAIT_START :
                  (state == WAIT_START & wfg_pat_start_i) ? RUN : state;
        duty_n  = !en_i ? '0 : (acc_ev & wfg_axis_tvalid_i) ? wfg_axis_tdata_i[CNT_W-1:0] : duty_q;
        phase_n = (!en_i | acc_ev) ? '0 :
                  (state == RUN & wfg_pat_subcycle_i) ? (wrap ? '0 : phase_q + 1'b1) : phase_q;
    end
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state      <= IDLE;
            phase_q    <= '0;
            duty_q     <= '0;
            pwm_q      <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state      <= state_n;
            phase_q    <= phase_n;
            duty_q     <= duty_n;
            pwm_q      <= (state_n == RUN) & (phase_n < duty_n);
            underrun_q <= acc_ev & !wfg_axis_tvalid_i;
        end
    end
`ifdef WFG_DRIVE_PWM_UNDERRUN_CNT_EN
    logic [15:0] cnt_q;
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i | !en_i)
            cnt_q <= '0;
        else if (acc_ev & !wfg_axis_tvalid_i & cnt_q != 16'hFFFF)
            cnt_q <= cnt_q + 1'b1;
    end
    assign underrun_cnt_o = cnt_q;
`endif
    assign wfg_axis_tready_o = acc_ev;
    assign pwm_o             = pwm_q ^ polarity_i;
    assign active_o          = state == RUN;
    assign underrun_o        = underrun_q;
endmodule

// File: tb/tb_wfg_drive_pwm.sv
// tb_wfg_drive_pwm: directed self-checking bench for wfg_drive_pwm.
module tb_wfg_drive_pwm;
    logic        clk = 0, rst = 1, en = 0, polarity = 0;
    logic        sync = 0, sub = 0, start = 0, tvalid = 0;
    logic [7:0]  period = 0;
    logic [31:0] tdata = 0;
    logic        tready, pwm, active, underrun, tr;
`ifdef WFG_DRIVE_PWM_UNDERRUN_CNT_EN
    logic [15:0] cnt;
`endif
    int total = 0, bad = 0;

    wfg_drive_pwm #(.DATA_W(32), .CNT_W(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .en_i(en), .period_i(period), .polarity_i(polarity),
        .wfg_pat_sync_i(sync), .wfg_pat_subcycle_i(sub), .wfg_pat_start_i(start),
        .wfg_axis_tdata_i(tdata), .wfg_axis_tvalid_i(tvalid), .wfg_axis_tready_o(tready),
        .pwm_o(pwm), .active_o(active),
`ifdef WFG_DRIVE_PWM_UNDERRUN_CNT_EN
        .underrun_cnt_o(cnt),
`endif
        .underrun_o(underrun));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse(input logic s, input logic u, input logic st, output logic t);
        sync = s; sub = u; start = st;
        #1 t = tready;
        step();
        sync = 0; sub = 0; start = 0;
    endtask

    task automatic test_reset();
        rst = 1; polarity = 0;
        step(); step();
        rst = 0;
        step();
        total++; if (pwm !== 1'b0) begin bad++; $display("FAIL reset_pwm got=%b exp=0", pwm); end
        total++; if (tready !== 1'b0) begin bad++; $display("FAIL reset_tready got=%b exp=0", tready); end
        total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b exp=0", active); end
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL reset_underrun got=%b exp=0", underrun); end
        polarity = 1; #1;
        total++; if (pwm !== 1'b1) begin bad++; $display("FAIL idle_polarity got=%b exp=1", pwm); end
        polarity = 0; #1;
    endtask

    task automatic test_basic();
        logic e;
        en = 1; period = 4; tvalid = 1; tdata = 2;
        step();
        pulse(1, 0, 0, tr);
        total++; if (tr !== 1'b0) begin bad++; $display("FAIL sync_without_start_tready got=%b exp=0", tr); end
        pulse(1, 0, 1, tr);
        total++; if (tr !== 1'b1) begin bad++; $display("FAIL start_tready got=%b exp=1", tr); end
        total++; if (active !== 1'b1) begin bad++; $display("FAIL start_active got=%b exp=1", active); end
        total++; if (pwm !== 1'b1) begin bad++; $display("FAIL start_pwm_phase0 got=%b exp=1", pwm); end
        for (int i = 1; i <= 8; i++) begin
            pulse(0, 1, 0, tr);
            e = (i % 4) < 2;
            total++; if (pwm !== e || tr !== 1'b0) begin bad++; $display("FAIL basic_sub%0d pwm=%b exp=%b tready=%b", i, pwm, e, tr); end
        end
    endtask

    task automatic test_underrun();
`ifdef WFG_DRIVE_PWM_UNDERRUN_CNT_EN
        total++; if (cnt !== 16'd0) begin bad++; $display("FAIL cnt_before got=%0d exp=0", cnt); end
`endif
        tvalid = 0; tdata = 3;
        pulse(1, 0, 0, tr);
        total++; if (tr !== 1'b1) begin bad++; $display("FAIL underrun_tready got=%b exp=1", tr); end
        total++; if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_pulse got=%b exp=1", underrun); end
`ifdef WFG_DRIVE_PWM_UNDERRUN_CNT_EN
        total++; if (cnt !== 16'd1) begin bad++; $display("FAIL cnt_after got=%0d exp=1", cnt); end
`endif
        step();
        total++; if (underrun !== 1'b0) begin bad++; $display("FAIL underrun_width got=%b exp=0", underrun); end
        pulse(0, 1, 0, tr);
        total++; if (pwm !== 1'b1) begin bad++; $display("FAIL held_duty_ph1 got=%b exp=1", pwm); end
        pulse(0, 1, 0, tr);
        total++; if (pwm !== 1'b0) begin bad++; $display("FAIL held_duty_ph2 got=%b exp=0", pwm); end
        tvalid = 1;
    endtask

    task automatic test_boundary();
        logic [7:0] duties [3] = '{8'd0, 8'd4, 8'd200};
        int hi;
        period = 4;
        for (int k = 0; k < 3; k++) begin
            tdata = {24'd0, duties[k]};
            pulse(1, 0, 0, tr);
            hi = (pwm === 1'b1);
            for (int i = 0; i < 4; i++) begin
                pulse(0, 1, 0, tr);
                hi += (pwm === 1'b1);
            end
            total++; if (hi != (duties[k] == 0 ? 0 : 5)) begin bad++; $display("FAIL boundary_duty%0d high=%0d exp=%0d", duties[k], hi, duties[k] == 0 ? 0 : 5); end
        end
        period = 0; tdata = 255;
        pulse(1, 0, 0, tr);
        total++; if (pwm !== 1'b1) begin bad++; $display("FAIL p256_phase0 got=%b exp=1", pwm); end
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            pulse(0, 1, 0, tr);
            hi += (pwm === 1'b1);
            if (i == 254) begin
                total++; if (pwm !== 1'b0) begin bad++; $display("FAIL p256_phase255 got=%b exp=0", pwm); end
            end
        end
        total++; if (hi != 255) begin bad++; $display("FAIL p256_high_count got=%0d exp=255", hi); end
    endtask

    task automatic test_sync_sub();
        period = 4; tdata = 2;
        pulse(1, 0, 0, tr);
        repeat (3) pulse(0, 1, 0, tr);
        total++; if (pwm !== 1'b0) begin bad++; $display("FAIL phase3_pwm got=%b exp=0", pwm); end
        tdata = 1;
        pulse(1, 1, 0, tr);
        total++; if (tr !== 1'b1 || pwm !== 1'b1) begin bad++; $display("FAIL sync_sub_same tready=%b pwm=%b exp=1,1", tr, pwm); end
        pulse(0, 1, 0, tr);
        total++; if (pwm !== 1'b0) begin bad++; $display("FAIL sync_sub_newduty got=%b exp=0", pwm); end
    endtask

    task automatic test_period_change();
        pulse(0, 1, 0, tr);
        total++; if (pwm !== 1'b0) begin bad++; $display("FAIL pchg_phase2 got=%b exp=0", pwm); end
        period = 2;
        pulse(0, 1, 0, tr);
        total++; if (pwm !== 1'b1) begin bad++; $display("FAIL pchg_wrap got=%b exp=1", pwm); end
        period = 4;
    endtask

    task automatic test_en_drop();
        polarity = 1; tdata = 3;
        pulse(1, 0, 0, tr);
        repeat (2) pulse(0, 1, 0, tr);
        total++; if (pwm !== 1'b0) begin bad++; $display("FAIL drop_pre_pwm got=%b exp=0", pwm); end
        en = 0;
        step();
        total++; if (active !== 1'b0 || pwm !== 1'b1) begin bad++; $display("FAIL drop_idle active=%b pwm=%b exp=0,1", active, pwm); end
`ifdef WFG_DRIVE_PWM_UNDERRUN_CNT_EN
        total++; if (cnt !== 16'd0) begin bad++; $display("FAIL drop_cnt got=%0d exp=0", cnt); end
`endif
        en = 1;
        step();
        pulse(1, 0, 0, tr);
        total++; if (tr !== 1'b0 || active !== 1'b0) begin bad++; $display("FAIL reen_wait tready=%b active=%b exp=0,0", tr, active); end
        pulse(1, 0, 1, tr);
        total++; if (tr !== 1'b1 || active !== 1'b1 || pwm !== 1'b0) begin bad++; $display("FAIL reen_start tready=%b active=%b pwm=%b exp=1,1,0", tr, active, pwm); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_boundary();
        test_sync_sub();
        test_period_change();
        test_en_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
